// File: rtl/cache_pkg.sv
// Shared state encoding and request-type constants for the cache request sequencer.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        RESPOND,
        WB_READ,
        WB_WAIT,
        ALLOCATE,
        ERROR
    } ctrl_state_e;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/cache_controller_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ack; expired flags the last permitted wait cycle.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TW'(1);
        end
    end

    // Asserted during the TIMEOUT_CYCLES-th wait cycle; an ack in that cycle still takes priority.
    assign expired = enable && (count == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cache_controller.sv
// Request sequencer in front of the 4-way set-associative array: lookup, write-back,
// refill with replay, memory timeout handling and saturating hit/miss statistics.
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_type,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic                  cpu_resp_valid,
    output logic                  cpu_resp_error,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [WORD_SIZE-1:0]  cache_wdata,
    output logic                  req_type,
    input  logic                  hit,
    input  logic                  dirty_bit,
    output logic                  read_en_cache,
    output logic                  write_en_cache,
    output logic                  read_en_mem,
    output logic                  write_en_mem,
    output logic                  mem_req_valid,
    output logic                  mem_req_we,
    input  logic                  mem_ack,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    ctrl_state_e state, state_next;
    logic        replay;
    logic        in_wait;
    logic        timer_expired;

    assign in_wait = (state == WB_WAIT) || (state == ALLOCATE);

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_wait || mem_ack),
        .enable (in_wait),
        .expired(timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cache_addr  <= '0;
            cache_wdata <= '0;
            req_type    <= REQ_READ;
            replay      <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && cpu_req_valid) begin
                cache_addr  <= cpu_addr;
                cache_wdata <= cpu_wdata;
                req_type    <= cpu_req_type;
                replay      <= 1'b0;
            end else if (state == ALLOCATE && mem_ack) begin
                replay <= 1'b1;
            end
        end
    end

    // Statistics only reflect the first lookup of each request, never the post-refill replay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == COMPARE && !replay) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + CNT_WIDTH'(1);
            end else begin
                if (miss_count != '1) miss_count <= miss_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_next     = state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_error = 1'b0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_we     = 1'b0;

        case (state)
            IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) state_next = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    if (req_type == REQ_READ) read_en_cache  = 1'b1;
                    else                      write_en_cache = 1'b1;
                    state_next = RESPOND;
                end else if (replay) begin
                    state_next = ERROR;
                end else if (dirty_bit) begin
                    state_next = WB_READ;
                end else begin
                    state_next = ALLOCATE;
                end
            end
            RESPOND: begin
                cpu_resp_valid = 1'b1;
                state_next     = IDLE;
            end
            WB_READ: begin
                read_en_cache  = 1'b1;
                write_en_cache = 1'b1;
                read_en_mem    = 1'b1;
                write_en_mem   = 1'b1;
                state_next     = WB_WAIT;
            end
            WB_WAIT: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                if (mem_ack)            state_next = ALLOCATE;
                else if (timer_expired) state_next = ERROR;
            end
            ALLOCATE: begin
                mem_req_valid = 1'b1;
                if (mem_ack) begin
                    read_en_mem    = 1'b1;
                    write_en_cache = 1'b1;
                    state_next     = COMPARE;
                end else if (timer_expired) begin
                    state_next = ERROR;
                end
            end
            ERROR: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_error = 1'b1;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized transaction-level bench for cache_controller; the bench plays array and memory
// and predicts each request's outcome from the request/miss/ack timing rules.
module tb_cache_controller;

    localparam int unsigned T   = 4;
    localparam int unsigned CW  = 2;
    localparam int          MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic          cpu_req_type;
    logic [31:0]   cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_resp_valid;
    logic          cpu_resp_error;
    logic [31:0]   cache_addr;
    logic [31:0]   cache_wdata;
    logic          req_type;
    logic          hit;
    logic          dirty_bit;
    logic          read_en_cache;
    logic          write_en_cache;
    logic          read_en_mem;
    logic          write_en_mem;
    logic          mem_req_valid;
    logic          mem_req_we;
    logic          mem_ack;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    always #5 clk = ~clk;

    cache_controller #(
        .ADDR_WIDTH    (32),
        .WORD_SIZE     (32),
        .TIMEOUT_CYCLES(T),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_type  (cpu_req_type),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_error(cpu_resp_error),
        .cache_addr    (cache_addr),
        .cache_wdata   (cache_wdata),
        .req_type      (req_type),
        .hit           (hit),
        .dirty_bit     (dirty_bit),
        .read_en_cache (read_en_cache),
        .write_en_cache(write_en_cache),
        .read_en_mem   (read_en_mem),
        .write_en_mem  (write_en_mem),
        .mem_req_valid (mem_req_valid),
        .mem_req_we    (mem_req_we),
        .mem_ack       (mem_ack),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_hits = 0;
        exp_miss = 0;
    endtask

    // One CPU request. fh/fd: first-lookup hit/dirty; dw/da: ack delay (cycles without ack)
    // for write-back/refill; rh: hit on the replay lookup; hold: keep cpu_req_valid high while busy.
    task automatic run_txn(input bit typ, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit fh, input bit fd, input int dw, input int da,
                           input bit rh, input bit hold);
        bit wb, wb_to, al_to, fill, fin_hit, err, done, fill_seen, wb_seen, got_err;
        int exp_resp, s, cyc, rc, wc, rm, wm, wec, rdy, wbcnt, acnt;
        logic [31:0] seen_addr, seen_wdata, seen_type, seen_hc, seen_mc;

        wb      = !fh && fd;
        wb_to   = wb && (dw >= T);
        al_to   = !fh && !wb_to && (da >= T);
        fill    = !fh && !wb_to && !al_to;
        fin_hit = fh || (fill && rh);
        err     = !fin_hit;
        if (fh) begin
            exp_resp = 2;
        end else begin
            s = wb ? 3 : 2;
            if (wb_to)      exp_resp = s + T;
            else begin
                if (wb) s = s + dw + 1;
                exp_resp = al_to ? s + T : s + da + 2;
            end
        end
        if (fh) exp_hits = (exp_hits < MAXC) ? exp_hits + 1 : MAXC;
        else    exp_miss = (exp_miss < MAXC) ? exp_miss + 1 : MAXC;

        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_type  = typ;
        cpu_addr      = addr;
        cpu_wdata     = wdata;
        hit           = fh;
        dirty_bit     = fd;
        mem_ack       = 1'b0;
        #1 check("ready_idle", cpu_req_ready, 1);
        @(posedge clk);

        {done, fill_seen, wb_seen, got_err} = '0;
        {cyc, rc, wc, rm, wm, wec, rdy, wbcnt, acnt} = '0;
        {seen_addr, seen_wdata, seen_type, seen_hc, seen_mc} = '0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (!hold) cpu_req_valid = 1'b0;
            cpu_req_type = 1'($urandom);
            cpu_addr     = $urandom;
            cpu_wdata    = $urandom;
            hit          = fill_seen ? rh : fh;
            dirty_bit    = fill_seen ? 1'($urandom) : (wb_seen ? 1'b0 : fd);
            if (mem_req_valid) begin
                if (mem_req_we) begin mem_ack = (wbcnt == dw); wbcnt++; end
                else            begin mem_ack = (acnt == da);  acnt++;  end
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0);
            end
            #1;
            rc  += int'(read_en_cache);
            wc  += int'(write_en_cache);
            rm  += int'(read_en_mem);
            wm  += int'(write_en_mem);
            wec += int'(mem_req_valid && mem_req_we);
            rdy += int'(cpu_req_ready);
            if (read_en_mem && !write_en_mem) fill_seen = 1'b1;
            if (write_en_mem) wb_seen = 1'b1;
            if (cpu_resp_valid) begin
                done       = 1'b1;
                got_err    = cpu_resp_error;
                seen_addr  = cache_addr;
                seen_wdata = cache_wdata;
                seen_type  = 32'(req_type);
                seen_hc    = 32'(hit_count);
                seen_mc    = 32'(miss_count);
            end
        end
        cpu_req_valid = 1'b0;
        mem_ack       = 1'b0;

        if (!done) begin
            check("resp_wait_bound", 0, 1);
            do_reset();
        end else begin
            check("resp_cycle", cyc, exp_resp);
            check("resp_error", 32'(got_err), 32'(err));
            check("read_en_cache_cnt", rc, int'(wb) + int'(fin_hit && typ == 1'b0));
            check("write_en_cache_cnt", wc, int'(wb) + int'(fill) + int'(fin_hit && typ == 1'b1));
            check("read_en_mem_cnt", rm, int'(wb) + int'(fill));
            check("write_en_mem_cnt", wm, int'(wb));
            check("wb_req_cycles", wec, wb ? (wb_to ? T : dw + 1) : 0);
            check("ready_busy", rdy, 0);
            check("cache_addr", seen_addr, addr);
            check("cache_wdata", seen_wdata, wdata);
            check("req_type", seen_type, 32'(typ));
            check("hit_count", seen_hc, exp_hits);
            check("miss_count", seen_mc, exp_miss);
        end
    endtask

    task automatic reset_mid_alloc();
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_type  = 1'b1;
        cpu_addr      = 32'h0000_3300;
        cpu_wdata     = 32'hDEAD_BEEF;
        hit           = 1'b0;
        dirty_bit     = 1'b0;
        mem_ack       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        @(negedge clk);
        #1 check("alloc_before_reset", 32'(mem_req_valid), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mem_req_valid", 32'(mem_req_valid), 0);
        check("rst_ready", 32'(cpu_req_ready), 1);
        check("rst_hit_count", 32'(hit_count), 0);
        check("rst_miss_count", 32'(miss_count), 0);
        check("rst_cache_addr", cache_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_hits = 0;
        exp_miss = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n         = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_req_type  = 1'b0;
        cpu_addr      = '0;
        cpu_wdata     = '0;
        hit           = 1'b0;
        dirty_bit     = 1'b0;
        mem_ack       = 1'b0;
        #3;
        check("reset_ready", 32'(cpu_req_ready), 1);
        check("reset_resp", {cpu_resp_valid, cpu_resp_error}, 0);
        check("reset_strobes", {read_en_cache, write_en_cache, read_en_mem, write_en_mem}, 0);
        check("reset_mem", {mem_req_valid, mem_req_we}, 0);
        check("reset_counts", {hit_count, miss_count}, 0);
        check("reset_latches", {cache_addr ^ cache_wdata, 31'b0, req_type}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(1'b0, 32'h0000_0104, 32'h1111_0000, 1, 0, 0, 0, 1, 0);   // read hit
        run_txn(1'b1, 32'h0000_2208, 32'hCAFE_F00D, 0, 0, 0, 3, 1, 0);   // clean miss write
        run_txn(1'b0, 32'h0000_4410, 32'h0,         0, 1, 2, 1, 1, 0);   // dirty miss
        run_txn(1'b0, 32'h0000_5000, 32'h5,         0, 0, 0, 100, 1, 0); // refill timeout
        run_txn(1'b1, 32'h0000_5004, 32'h6,         0, 1, 100, 0, 1, 0); // write-back timeout
        run_txn(1'b0, 32'h0000_5008, 32'h7,         0, 0, 0, T - 1, 1, 0); // ack on last cycle
        run_txn(1'b1, 32'h0000_500C, 32'h8,         0, 1, T - 1, T - 1, 1, 0);
        run_txn(1'b0, 32'h0000_5010, 32'h9,         0, 0, 0, T, 1, 0);   // one cycle too late
        run_txn(1'b1, 32'h0000_6000, 32'hA,         0, 1, 0, 0, 0, 0);   // replay miss
        run_txn(1'b1, 32'h0000_7000, 32'hB,         0, 1, 1, 2, 1, 1);   // valid held while busy
        reset_mid_alloc();
        for (int i = 0; i < 5; i++)
            run_txn(1'($urandom), $urandom, $urandom, 1, 1'($urandom), 0, 0, 1, 1'($urandom));

        for (int i = 0; i < 150; i++) begin
            run_txn(1'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 9) < 4), 1'($urandom),
                    $urandom_range(0, T + 1), $urandom_range(0, T + 1),
                    ($urandom_range(0, 9) != 0), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
